// File: rtl/spart_bus_ctrl_if.sv
// Handshake bundle between spart_bus_ctrl, the SPART control/status lines,
// the two transmit requesters and the receive consumer.
interface spart_bus_ctrl_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rda;
    logic       tbr;
    logic [7:0] tx0_data;
    logic       tx0_valid;
    logic       tx0_ready;
    logic [7:0] tx1_data;
    logic       tx1_valid;
    logic       tx1_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (
        output iocs, iorw, ioaddr, tx0_ready, tx1_ready, rx_data, rx_valid,
        input  rda, tbr, tx0_data, tx0_valid, tx1_data, tx1_valid, rx_ready
    );

    modport slave (
        input  iocs, iorw, ioaddr, tx0_ready, tx1_ready, rx_data, rx_valid,
        output rda, tbr, tx0_data, tx0_valid, tx1_data, tx1_valid, rx_ready
    );
endinterface

// File: rtl/spart_bus_ctrl.sv
// Sole master of the SPART processor bus: programs the baud divisor, arbitrates
// two transmit requesters round-robin and drains received bytes into a holding register.
module spart_bus_ctrl #(
    parameter logic [15:0] DIV0 = 16'd1301,
    parameter logic [15:0] DIV1 = 16'd650,
    parameter logic [15:0] DIV2 = 16'd325,
    parameter logic [15:0] DIV3 = 16'd162
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      br_cfg,
    inout  wire  [7:0]      databus,
    output logic            cfg_done,
    spart_bus_ctrl_if.master bus
);

    typedef enum logic [2:0] {CFG_LO, CFG_HI, IDLE, RX, TX, GAP} state_e;

    state_e     state_q, state_d;
    logic       started_q;
    logic [1:0] cfg_q, cfg_d;
    logic       rr_q, rr_d;
    logic       iocs_q, iocs_d;
    logic       iorw_q, iorw_d;
    logic [1:0] ioaddr_q, ioaddr_d;
    logic       drive_q, drive_d;
    logic [7:0] dout_q, dout_d;
    logic       tx0_ready_q, tx0_ready_d;
    logic       tx1_ready_q, tx1_ready_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       cfg_done_q, cfg_done_d;
    logic       grant;
    logic [15:0] div_sel;

    function automatic logic [15:0] div_of(input logic [1:0] sel);
        case (sel)
            2'd0:    return DIV0;
            2'd1:    return DIV1;
            2'd2:    return DIV2;
            default: return DIV3;
        endcase
    endfunction

    // A lone requester wins outright; rr only breaks ties.
    always_comb begin
        if (bus.tx0_valid && bus.tx1_valid) grant = rr_q;
        else                                grant = bus.tx1_valid;
    end

    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        rr_d        = rr_q;
        tx0_ready_d = 1'b0;
        tx1_ready_d = 1'b0;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q & ~bus.rx_ready;
        cfg_done_d  = cfg_done_q;
        iocs_d      = 1'b0;
        iorw_d      = 1'b1;
        ioaddr_d    = 2'b00;
        drive_d     = 1'b0;
        dout_d      = '0;

        // Outputs are registered from state_d, so the IDLE decision is also taken
        // while leaving GAP; this keeps back-to-back accesses two cycles apart.
        case (state_q)
            CFG_LO: if (started_q) state_d = CFG_HI;
            CFG_HI: begin
                state_d    = GAP;
                cfg_done_d = 1'b1;
            end
            RX: begin
                rx_data_d  = databus;
                rx_valid_d = 1'b1;
                state_d    = GAP;
            end
            TX: state_d = GAP;
            IDLE, GAP: begin
                if (br_cfg != cfg_q) begin
                    state_d    = CFG_LO;
                    cfg_done_d = 1'b0;
                end else if (bus.rda && !rx_valid_q) begin
                    state_d = RX;
                end else if (bus.tbr && (bus.tx0_valid || bus.tx1_valid)) begin
                    state_d     = TX;
                    rr_d        = ~grant;
                    tx0_ready_d = ~grant;
                    tx1_ready_d = grant;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = CFG_LO;
        endcase

        if (state_d == CFG_LO) cfg_d = br_cfg;
        div_sel = div_of(cfg_d);

        case (state_d)
            CFG_LO: begin
                iocs_d   = 1'b1;
                iorw_d   = 1'b0;
                ioaddr_d = 2'b10;
                drive_d  = 1'b1;
                dout_d   = div_sel[7:0];
            end
            CFG_HI: begin
                iocs_d   = 1'b1;
                iorw_d   = 1'b0;
                ioaddr_d = 2'b11;
                drive_d  = 1'b1;
                dout_d   = div_sel[15:8];
            end
            RX: begin
                iocs_d = 1'b1;
                iorw_d = 1'b1;
            end
            TX: begin
                iocs_d  = 1'b1;
                iorw_d  = 1'b0;
                drive_d = 1'b1;
                dout_d  = grant ? bus.tx1_data : bus.tx0_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CFG_LO;
            started_q   <= 1'b0;
            cfg_q       <= 2'b00;
            rr_q        <= 1'b0;
            iocs_q      <= 1'b0;
            iorw_q      <= 1'b1;
            ioaddr_q    <= 2'b00;
            drive_q     <= 1'b0;
            dout_q      <= '0;
            tx0_ready_q <= 1'b0;
            tx1_ready_q <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            cfg_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            started_q   <= 1'b1;
            cfg_q       <= cfg_d;
            rr_q        <= rr_d;
            iocs_q      <= iocs_d;
            iorw_q      <= iorw_d;
            ioaddr_q    <= ioaddr_d;
            drive_q     <= drive_d;
            dout_q      <= dout_d;
            tx0_ready_q <= tx0_ready_d;
            tx1_ready_q <= tx1_ready_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            cfg_done_q  <= cfg_done_d;
        end
    end

    assign databus       = drive_q ? dout_q : 'z;
    assign bus.iocs      = iocs_q;
    assign bus.iorw      = iorw_q;
    assign bus.ioaddr    = ioaddr_q;
    assign bus.tx0_ready = tx0_ready_q;
    assign bus.tx1_ready = tx1_ready_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign cfg_done      = cfg_done_q;

endmodule

// File: tb/tb_spart_bus_ctrl.sv
// Directed bench for spart_bus_ctrl: divisor programming, TX arbitration,
// RX holding, RX-over-TX priority, br_cfg change and mid-access reset.
module tb_spart_bus_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] br_cfg;
    wire  [7:0] databus;
    logic       cfg_done;
    logic [7:0] spart_byte;
    int         errors = 0;
    int         checks = 0;

    spart_bus_ctrl_if bus_if ();

    spart_bus_ctrl #(
        .DIV0(16'd1301),
        .DIV1(16'd650),
        .DIV2(16'd325),
        .DIV3(16'd162)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .br_cfg  (br_cfg),
        .databus (databus),
        .cfg_done(cfg_done),
        .bus     (bus_if)
    );

    // SPART model: drives the bus during a read strobe
    assign databus = (bus_if.iocs && bus_if.iorw) ? spart_byte : 8'hzz;

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick(); tick();
        checks++;
        if ({bus_if.iocs, bus_if.iorw, bus_if.ioaddr} !== 4'b0100) begin
            errors++; $display("FAIL reset_bus: got %b expected 0100", {bus_if.iocs, bus_if.iorw, bus_if.ioaddr});
        end
        checks++;
        if ({bus_if.tx0_ready, bus_if.tx1_ready, bus_if.rx_valid, cfg_done, bus_if.rx_data} !== {4'b0000, 8'h00}) begin
            errors++; $display("FAIL reset_outputs: got %b_%b_%b_%b_%h expected 0_0_0_0_00",
                               bus_if.tx0_ready, bus_if.tx1_ready, bus_if.rx_valid, cfg_done, bus_if.rx_data);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({bus_if.iocs, bus_if.iorw, bus_if.ioaddr, databus, cfg_done} !== {4'b1010, 8'hA2, 1'b0}) begin
            errors++; $display("FAIL cfg_lo_11: got %b_%h_%b expected 1010_a2_0", {bus_if.iocs, bus_if.iorw, bus_if.ioaddr}, databus, cfg_done);
        end
        tick();
        checks++;
        if ({bus_if.iocs, bus_if.iorw, bus_if.ioaddr, databus, cfg_done} !== {4'b1011, 8'h00, 1'b0}) begin
            errors++; $display("FAIL cfg_hi_11: got %b_%h_%b expected 1011_00_0", {bus_if.iocs, bus_if.iorw, bus_if.ioaddr}, databus, cfg_done);
        end
        tick();
        checks++;
        if ({bus_if.iocs, bus_if.iorw, cfg_done} !== 3'b011) begin
            errors++; $display("FAIL cfg_gap: got %b expected 011", {bus_if.iocs, bus_if.iorw, cfg_done});
        end
        tick();
        checks++;
        if ({bus_if.iocs, cfg_done} !== 2'b01) begin
            errors++; $display("FAIL post_cfg_idle: got %b expected 01", {bus_if.iocs, cfg_done});
        end
    endtask

    task automatic test_single_tx();
        bus_if.tbr = 1'b1; bus_if.tx0_data = 8'h55; bus_if.tx0_valid = 1'b1;
        tick();
        checks++;
        if ({bus_if.iocs, bus_if.iorw, bus_if.ioaddr, databus} !== {4'b1000, 8'h55}) begin
            errors++; $display("FAIL tx0_write: got %b_%h expected 1000_55", {bus_if.iocs, bus_if.iorw, bus_if.ioaddr}, databus);
        end
        checks++;
        if ({bus_if.tx0_ready, bus_if.tx1_ready} !== 2'b10) begin
            errors++; $display("FAIL tx0_ready: got %b expected 10", {bus_if.tx0_ready, bus_if.tx1_ready});
        end
        bus_if.tx0_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({bus_if.iocs, bus_if.iorw, bus_if.tx0_ready, bus_if.tx1_ready} !== 4'b0100) begin
                errors++; $display("FAIL tx0_after[%0d]: got %b expected 0100", i, {bus_if.iocs, bus_if.iorw, bus_if.tx0_ready, bus_if.tx1_ready});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_byte;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_if.tx0_data = 8'hA1; bus_if.tx0_valid = 1'b1;
        bus_if.tx1_data = 8'hB2; bus_if.tx1_valid = 1'b1;
        bus_if.tbr = 1'b1;
        tick(); tick(); tick();
        checks++;
        if ({bus_if.iocs, bus_if.tx0_ready, bus_if.tx1_ready, cfg_done} !== 4'b0001) begin
            errors++; $display("FAIL b2b_cfg_gap: got %b expected 0001", {bus_if.iocs, bus_if.tx0_ready, bus_if.tx1_ready, cfg_done});
        end
        for (int i = 0; i < 4; i++) begin
            exp_byte = (i % 2 == 0) ? 8'hA1 : 8'hB2;
            tick();
            checks++;
            if ({bus_if.iocs, bus_if.iorw, bus_if.ioaddr, databus} !== {4'b1000, exp_byte}) begin
                errors++; $display("FAIL b2b_write[%0d]: got %b_%h expected 1000_%h", i, {bus_if.iocs, bus_if.iorw, bus_if.ioaddr}, databus, exp_byte);
            end
            checks++;
            if ({bus_if.tx0_ready, bus_if.tx1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL b2b_ready[%0d]: got %b expected %b", i, {bus_if.tx0_ready, bus_if.tx1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
            end
            tick();
            checks++;
            if ({bus_if.iocs, bus_if.tx0_ready, bus_if.tx1_ready} !== 3'b000) begin
                errors++; $display("FAIL b2b_gap[%0d]: got %b expected 000", i, {bus_if.iocs, bus_if.tx0_ready, bus_if.tx1_ready});
            end
        end
        bus_if.tbr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({bus_if.iocs, bus_if.tx0_ready, bus_if.tx1_ready} !== 3'b000) begin
                errors++; $display("FAIL tbr_low[%0d]: got %b expected 000", i, {bus_if.iocs, bus_if.tx0_ready, bus_if.tx1_ready});
            end
        end
        // rr now points at requester 0, yet a lone tx1 must still win
        bus_if.tx0_valid = 1'b0; bus_if.tbr = 1'b1;
        tick();
        checks++;
        if ({bus_if.iocs, databus, bus_if.tx0_ready, bus_if.tx1_ready} !== {1'b1, 8'hB2, 2'b01}) begin
            errors++; $display("FAIL lone_tx1: got %b_%h_%b expected 1_b2_01", bus_if.iocs, databus, {bus_if.tx0_ready, bus_if.tx1_ready});
        end
        bus_if.tx1_valid = 1'b0; bus_if.tx0_valid = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus_if.iocs, databus, bus_if.tx0_ready, bus_if.tx1_ready} !== {1'b1, 8'hA1, 2'b10}) begin
            errors++; $display("FAIL lone_tx0: got %b_%h_%b expected 1_a1_10", bus_if.iocs, databus, {bus_if.tx0_ready, bus_if.tx1_ready});
        end
        bus_if.tx0_valid = 1'b0; bus_if.tbr = 1'b0;
        tick(); tick();
    endtask

    task automatic test_rx_hold();
        spart_byte = 8'h3C; bus_if.rda = 1'b1; bus_if.rx_ready = 1'b0;
        tick();
        checks++;
        if ({bus_if.iocs, bus_if.iorw, bus_if.ioaddr, databus} !== {4'b1100, 8'h3C}) begin
            errors++; $display("FAIL rx_read: got %b_%h expected 1100_3c", {bus_if.iocs, bus_if.iorw, bus_if.ioaddr}, databus);
        end
        bus_if.rda = 1'b0;
        tick();
        checks++;
        if ({bus_if.iocs, bus_if.rx_valid, bus_if.rx_data} !== {2'b01, 8'h3C}) begin
            errors++; $display("FAIL rx_hold: got %b_%b_%h expected 0_1_3c", bus_if.iocs, bus_if.rx_valid, bus_if.rx_data);
        end
        spart_byte = 8'h7E; bus_if.rda = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({bus_if.iocs, bus_if.rx_valid, bus_if.rx_data} !== {2'b01, 8'h3C}) begin
                errors++; $display("FAIL rx_blocked[%0d]: got %b_%b_%h expected 0_1_3c", i, bus_if.iocs, bus_if.rx_valid, bus_if.rx_data);
            end
        end
        bus_if.rx_ready = 1'b1;
        tick();
        bus_if.rx_ready = 1'b0;
        checks++;
        if ({bus_if.iocs, bus_if.rx_valid} !== 2'b00) begin
            errors++; $display("FAIL rx_accept: got %b expected 00", {bus_if.iocs, bus_if.rx_valid});
        end
        tick();
        checks++;
        if ({bus_if.iocs, bus_if.iorw, bus_if.ioaddr, databus} !== {4'b1100, 8'h7E}) begin
            errors++; $display("FAIL rx_second_read: got %b_%h expected 1100_7e", {bus_if.iocs, bus_if.iorw, bus_if.ioaddr}, databus);
        end
        bus_if.rda = 1'b0;
        tick();
        checks++;
        if ({bus_if.rx_valid, bus_if.rx_data} !== {1'b1, 8'h7E}) begin
            errors++; $display("FAIL rx_second_data: got %b_%h expected 1_7e", bus_if.rx_valid, bus_if.rx_data);
        end
        bus_if.rx_ready = 1'b1;
        tick();
        bus_if.rx_ready = 1'b0;
        checks++;
        if (bus_if.rx_valid !== 1'b0) begin
            errors++; $display("FAIL rx_second_accept: got %b expected 0", bus_if.rx_valid);
        end
    endtask

    task automatic test_rx_priority();
        spart_byte = 8'hC3; bus_if.rda = 1'b1;
        bus_if.tx0_data = 8'h5A; bus_if.tx0_valid = 1'b1; bus_if.tbr = 1'b1;
        tick();
        checks++;
        if ({bus_if.iocs, bus_if.iorw, bus_if.ioaddr, bus_if.tx0_ready} !== 5'b11000) begin
            errors++; $display("FAIL prio_rx_first: got %b expected 11000", {bus_if.iocs, bus_if.iorw, bus_if.ioaddr, bus_if.tx0_ready});
        end
        bus_if.rda = 1'b0;
        tick();
        checks++;
        if ({bus_if.iocs, bus_if.rx_valid, bus_if.rx_data} !== {2'b01, 8'hC3}) begin
            errors++; $display("FAIL prio_gap: got %b_%b_%h expected 0_1_c3", bus_if.iocs, bus_if.rx_valid, bus_if.rx_data);
        end
        tick();
        checks++;
        if ({bus_if.iocs, bus_if.iorw, bus_if.ioaddr, databus, bus_if.tx0_ready} !== {4'b1000, 8'h5A, 1'b1}) begin
            errors++; $display("FAIL prio_tx_second: got %b_%h_%b expected 1000_5a_1", {bus_if.iocs, bus_if.iorw, bus_if.ioaddr}, databus, bus_if.tx0_ready);
        end
        bus_if.tx0_valid = 1'b0; bus_if.tbr = 1'b0;
        tick();
        bus_if.rx_ready = 1'b1;
        tick();
        bus_if.rx_ready = 1'b0;
        tick();
    endtask

    task automatic test_cfg_change();
        checks++;
        if (cfg_done !== 1'b1) begin
            errors++; $display("FAIL cfg_done_before: got %b expected 1", cfg_done);
        end
        br_cfg = 2'b00;
        tick();
        checks++;
        if ({bus_if.iocs, bus_if.iorw, bus_if.ioaddr, databus, cfg_done} !== {4'b1010, 8'h15, 1'b0}) begin
            errors++; $display("FAIL recfg_lo: got %b_%h_%b expected 1010_15_0", {bus_if.iocs, bus_if.iorw, bus_if.ioaddr}, databus, cfg_done);
        end
        tick();
        checks++;
        if ({bus_if.iocs, bus_if.iorw, bus_if.ioaddr, databus, cfg_done} !== {4'b1011, 8'h05, 1'b0}) begin
            errors++; $display("FAIL recfg_hi: got %b_%h_%b expected 1011_05_0", {bus_if.iocs, bus_if.iorw, bus_if.ioaddr}, databus, cfg_done);
        end
        tick();
        checks++;
        if ({bus_if.iocs, cfg_done} !== 2'b01) begin
            errors++; $display("FAIL recfg_done: got %b expected 01", {bus_if.iocs, cfg_done});
        end
        tick();
    endtask

    task automatic test_reset_mid_tx();
        bus_if.tbr = 1'b1; bus_if.tx0_data = 8'h99; bus_if.tx0_valid = 1'b1;
        tick();
        checks++;
        if ({bus_if.iocs, bus_if.iorw, databus} !== {2'b10, 8'h99}) begin
            errors++; $display("FAIL midrst_tx: got %b_%h expected 10_99", {bus_if.iocs, bus_if.iorw}, databus);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({bus_if.iocs, bus_if.iorw, bus_if.tx0_ready, cfg_done} !== 4'b0100) begin
            errors++; $display("FAIL midrst_abort: got %b expected 0100", {bus_if.iocs, bus_if.iorw, bus_if.tx0_ready, cfg_done});
        end
        rst = 1'b0; bus_if.tx0_valid = 1'b0; bus_if.tbr = 1'b0;
        tick();
        checks++;
        if ({bus_if.iocs, bus_if.iorw, bus_if.ioaddr, databus} !== {4'b1010, 8'h15}) begin
            errors++; $display("FAIL midrst_restart: got %b_%h expected 1010_15", {bus_if.iocs, bus_if.iorw, bus_if.ioaddr}, databus);
        end
        tick();
        checks++;
        if ({bus_if.ioaddr, databus} !== {2'b11, 8'h05}) begin
            errors++; $display("FAIL midrst_hi: got %b_%h expected 11_05", bus_if.ioaddr, databus);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; br_cfg = 2'b11; spart_byte = 8'h00;
        bus_if.rda = 1'b0; bus_if.tbr = 1'b0; bus_if.rx_ready = 1'b0;
        bus_if.tx0_data = 8'h00; bus_if.tx0_valid = 1'b0;
        bus_if.tx1_data = 8'h00; bus_if.tx1_valid = 1'b0;
        test_reset();
        test_single_tx();
        test_back_to_back();
        test_rx_hold();
        test_rx_priority();
        test_cfg_change();
        test_reset_mid_tx();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
